// File: rtl/conv_pkg.sv
// Shared types and helpers for the parametrised convolution engine.
package conv_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD_W = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;
  localparam logic [1:0] ST_DRAIN  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_LOAD_W = ST_LOAD_W,
    S_RUN    = ST_RUN,
    S_DRAIN  = ST_DRAIN
  } state_t;

  // Never returns 0, so single-entry ranges still get a 1-bit counter.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int acc_w(input int w_width, input int pix_w, input int k);
    return w_width + pix_w + 2 * clog2(k) + 1;
  endfunction

  function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int ow);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/conv_mac_row.sv
// One kernel row: K-tap dot product of unsigned pixels with signed weights, purely combinational.
module conv_mac_row
  import conv_pkg::*;
#(
  parameter int PIX_W   = 1,
  parameter int W_WIDTH = 8,
  parameter int K       = 5,
  parameter int ACC_W   = 16
) (
  input  logic [K*PIX_W-1:0]      pix,
  input  logic [K*W_WIDTH-1:0]    w,
  output logic signed [ACC_W-1:0] dot
);

  localparam int PW = PIX_W + W_WIDTH + 1;

  logic signed [PW-1:0] a, b, prod;

  always_comb begin
    dot  = '0;
    a    = '0;
    b    = '0;
    prod = '0;
    for (int c = 0; c < K; c++) begin
      a    = $signed({{(W_WIDTH + 1){1'b0}}, pix[c*PIX_W +: PIX_W]});
      b    = $signed({{(PIX_W + 1){w[c*W_WIDTH + W_WIDTH - 1]}}, w[c*W_WIDTH +: W_WIDTH]});
      prod = a * b;
      dot  = dot + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/conv_engine_param.sv
// KxK sliding-window conv engine: column read to conv_rslt_vld is 4 cycles; strobe output, no back-pressure.
// Build option CONV_RELU_EN: clamp negative results to zero in the output stage.
module conv_engine_param
  import conv_pkg::*;
#(
  parameter int PIX_W   = 1,
  parameter int W_WIDTH = 8,
  parameter int B_WIDTH = 8,
  parameter int K       = 5,
  parameter int IMG_W   = 28,
  parameter int IMG_H   = 28,
  parameter int N_KER   = 30,
  parameter int OUT_W   = 16
) (
  input  logic                           sclk,
  input  logic                           s_rst_n,
  input  logic                           cal_start,
  output logic                           busy,
  output logic                           done,
  output logic [clog2(IMG_W)-1:0]        data_rd_addr,
  output logic [clog2(IMG_H)-1:0]        row_cnt,
  input  logic [K*PIX_W-1:0]             col_data,
  output logic [clog2(N_KER*K)-1:0]      param_rd_addr,
  output logic [clog2(N_KER)-1:0]        conv_cnt,
  input  logic [K*W_WIDTH-1:0]           param_w,
  input  logic signed [B_WIDTH-1:0]      param_bias,
  output logic signed [OUT_W-1:0]        conv_rslt,
  output logic                           conv_rslt_vld,
  output logic [clog2(IMG_W)-1:0]        rslt_col
);

  localparam int AW    = clog2(IMG_W);
  localparam int RW    = clog2(IMG_H);
  localparam int PAW   = clog2(N_KER * K);
  localparam int KW    = clog2(N_KER);
  localparam int LW    = clog2(K + 1);
  localparam int ACC_W = acc_w(W_WIDTH, PIX_W, K);

  localparam logic [AW-1:0] COL_LAST  = AW'(IMG_W - 1);
  localparam logic [AW-1:0] WIN_FIRST = AW'(K - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - K);
  localparam logic [KW-1:0] KER_LAST  = KW'(N_KER - 1);
  localparam logic [LW-1:0] LD_LAST   = LW'(K);
  localparam logic [LW-1:0] LD_ADDR_END = LW'(K - 1);

  state_t                         state;
  logic [LW-1:0]                  ld_cnt;
  logic [K-1:0][K*W_WIDTH-1:0]    w_arr;
  logic signed [B_WIDTH-1:0]      bias_r;

  logic                           rd_vld;
  logic [AW-1:0]                  rd_col;
  logic [K-1:1][K*PIX_W-1:0]      win;
  logic [K-1:0][K*PIX_W-1:0]      view;
  logic [K-1:0][ACC_W-1:0]        dot;

  logic                           s1_vld, s2_vld;
  logic [AW-1:0]                  s1_col, s2_col;
  logic [K-1:0][ACC_W-1:0]        s1_dot;
  logic signed [ACC_W-1:0]        s2_sum, row_sum;
  logic signed [63:0]             sat_v;
  logic signed [OUT_W-1:0]        res_c;

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      data_rd_addr  <= '0;
      row_cnt       <= '0;
      param_rd_addr <= '0;
      conv_cnt      <= '0;
      ld_cnt        <= '0;
      w_arr         <= '0;
      bias_r        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (cal_start) begin
          state         <= S_LOAD_W;
          busy          <= 1'b1;
          data_rd_addr  <= '0;
          row_cnt       <= '0;
          param_rd_addr <= '0;
          conv_cnt      <= '0;
          ld_cnt        <= '0;
        end
        S_LOAD_W: begin
          // Weight data trails the address by one cycle, hence K+1 cycles here.
          ld_cnt <= ld_cnt + LW'(1);
          if (ld_cnt != '0) w_arr <= {param_w, w_arr[K-1:1]};
          if (ld_cnt < LD_ADDR_END) param_rd_addr <= param_rd_addr + PAW'(1);
          if (ld_cnt == LD_LAST) begin
            bias_r <= param_bias;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (data_rd_addr == COL_LAST) begin
            data_rd_addr <= '0;
            if (row_cnt == ROW_LAST) begin
              row_cnt <= '0;
              if (conv_cnt == KER_LAST) begin
                state <= S_DRAIN;
              end else begin
                conv_cnt      <= conv_cnt + KW'(1);
                param_rd_addr <= param_rd_addr + PAW'(1);
                ld_cnt        <= '0;
                state         <= S_LOAD_W;
              end
            end else begin
              row_cnt <= row_cnt + RW'(1);
            end
          end else begin
            data_rd_addr <= data_rd_addr + AW'(1);
          end
        end
        S_DRAIN: if (!rd_vld && !s1_vld && !s2_vld) begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // The arriving column feeds stage1 directly, so the window only stores K-1 older columns.
  assign view = {col_data, win};

  for (genvar r = 0; r < K; r++) begin : g_row
    logic [K*PIX_W-1:0]   pix_r;
    logic [K*W_WIDTH-1:0] w_r;
    for (genvar c = 0; c < K; c++) begin : g_tap
      assign pix_r[c*PIX_W +: PIX_W]   = view[c][r*PIX_W +: PIX_W];
      assign w_r[c*W_WIDTH +: W_WIDTH] = w_arr[c][r*W_WIDTH +: W_WIDTH];
    end
    conv_mac_row #(
      .PIX_W  (PIX_W),
      .W_WIDTH(W_WIDTH),
      .K      (K),
      .ACC_W  (ACC_W)
    ) u_mac (
      .pix(pix_r),
      .w  (w_r),
      .dot(dot[r])
    );
  end

  always_comb begin
    row_sum = ACC_W'(bias_r);
    for (int r = 0; r < K; r++) row_sum = row_sum + $signed(s1_dot[r]);
  end

  always_comb begin
    sat_v = sat(64'(s2_sum), OUT_W);
    res_c = OUT_W'(sat_v);
`ifdef CONV_RELU_EN
    if (sat_v[63]) res_c = '0;
`endif
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      rd_vld        <= 1'b0;
      rd_col        <= '0;
      win           <= '0;
      s1_vld        <= 1'b0;
      s1_col        <= '0;
      s1_dot        <= '0;
      s2_vld        <= 1'b0;
      s2_col        <= '0;
      s2_sum        <= '0;
      conv_rslt     <= '0;
      conv_rslt_vld <= 1'b0;
      rslt_col      <= '0;
    end else begin
      rd_vld <= (state == S_RUN);
      rd_col <= data_rd_addr;
      if (rd_vld) begin
        if (rd_col == COL_LAST) win <= '0;
        else                    win <= view[K-1:1];
      end
      s1_vld        <= rd_vld && (rd_col >= WIN_FIRST);
      s1_col        <= rd_col - WIN_FIRST;
      s1_dot        <= dot;
      s2_vld        <= s1_vld;
      s2_col        <= s1_col;
      s2_sum        <= row_sum;
      conv_rslt_vld <= s2_vld;
      rslt_col      <= s2_col;
      conv_rslt     <= res_c;
    end
  end

endmodule

// File: tb/tb_conv_engine_param.sv
// Randomised and directed bench for conv_engine_param with ROM models and a queue-based scoreboard.
module tb_conv_engine_param;

  localparam int PIX_W = 8, W_WIDTH = 8, B_WIDTH = 8, K = 5;
  localparam int IMG_W = 9, IMG_H = 8, N_KER = 3, OUT_W = 16;
  localparam int AW = $clog2(IMG_W), RW = $clog2(IMG_H);
  localparam int PAW = $clog2(N_KER * K), KW = $clog2(N_KER);
  localparam int N_RES = N_KER * (IMG_H - K + 1) * (IMG_W - K + 1);

  logic                     sclk = 1'b0;
  logic                     s_rst_n = 1'b0;
  logic                     cal_start = 1'b0;
  logic                     busy, done, conv_rslt_vld;
  logic [AW-1:0]            data_rd_addr, rslt_col;
  logic [RW-1:0]            row_cnt;
  logic [PAW-1:0]           param_rd_addr;
  logic [KW-1:0]            conv_cnt;
  logic [K*PIX_W-1:0]       col_data = '0;
  logic [K*W_WIDTH-1:0]     param_w = '0;
  logic signed [B_WIDTH-1:0] param_bias;
  logic signed [OUT_W-1:0]  conv_rslt;

  int img [IMG_H][IMG_W];
  int wt  [N_KER][K][K];
  int bias [N_KER];

  typedef struct { int val; int col; } exp_t;
  exp_t q[$];
  exp_t e;
  int   ptrace[$];
  int   n_vec = 0, n_err = 0, done_cnt = 0, res_cnt = 0;
  longint cyc = 0, addr_cyc = -1;
  bit   lat_done = 1'b0;

  conv_engine_param #(
    .PIX_W(PIX_W), .W_WIDTH(W_WIDTH), .B_WIDTH(B_WIDTH), .K(K),
    .IMG_W(IMG_W), .IMG_H(IMG_H), .N_KER(N_KER), .OUT_W(OUT_W)
  ) dut (
    .sclk(sclk), .s_rst_n(s_rst_n), .cal_start(cal_start), .busy(busy), .done(done),
    .data_rd_addr(data_rd_addr), .row_cnt(row_cnt), .col_data(col_data),
    .param_rd_addr(param_rd_addr), .conv_cnt(conv_cnt), .param_w(param_w),
    .param_bias(param_bias), .conv_rslt(conv_rslt), .conv_rslt_vld(conv_rslt_vld),
    .rslt_col(rslt_col)
  );

  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc <= cyc + 1;

  // Image and parameter memories, one-cycle read latency.
  always @(posedge sclk) begin
    for (int r = 0; r < K; r++) begin
      if (int'(row_cnt) + r < IMG_H && int'(data_rd_addr) < IMG_W)
        col_data[r*PIX_W +: PIX_W] <= PIX_W'(img[int'(row_cnt) + r][int'(data_rd_addr)]);
      else
        col_data[r*PIX_W +: PIX_W] <= '0;
      if (int'(param_rd_addr) < N_KER * K)
        param_w[r*W_WIDTH +: W_WIDTH] <= W_WIDTH'(wt[int'(param_rd_addr) / K][r][int'(param_rd_addr) % K]);
      else
        param_w[r*W_WIDTH +: W_WIDTH] <= '0;
    end
  end

  assign param_bias = (int'(conv_cnt) < N_KER) ? B_WIDTH'(bias[int'(conv_cnt)]) : '0;

  task automatic chk(input string nm, input longint act, input longint exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  function automatic int clamp_out(input longint a);
    longint v;
    v = a;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
`ifdef CONV_RELU_EN
    if (v < 0) v = 0;
`endif
    return int'(v);
  endfunction

  task automatic push_expected();
    longint acc;
    for (int k = 0; k < N_KER; k++)
      for (int y = 0; y <= IMG_H - K; y++)
        for (int x = 0; x <= IMG_W - K; x++) begin
          acc = bias[k];
          for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
              acc += longint'(img[y + r][x + c]) * longint'(wt[k][r][c]);
          q.push_back('{clamp_out(acc), x});
        end
  endtask

  task automatic set_uniform(input int pix, input int w, input int b);
    for (int y = 0; y < IMG_H; y++) for (int x = 0; x < IMG_W; x++) img[y][x] = pix;
    for (int k = 0; k < N_KER; k++) begin
      bias[k] = b;
      for (int r = 0; r < K; r++) for (int c = 0; c < K; c++) wt[k][r][c] = w;
    end
  endtask

  task automatic rand_fill(input int pmax, input int wlo, input int whi);
    for (int y = 0; y < IMG_H; y++) for (int x = 0; x < IMG_W; x++) img[y][x] = int'($urandom_range(0, pmax));
    for (int k = 0; k < N_KER; k++) begin
      bias[k] = int'($urandom_range(0, 255)) - 128;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) wt[k][r][c] = int'($urandom_range(0, whi - wlo)) + wlo;
    end
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_vld"}, conv_rslt_vld, 0);
    chk({tag, "_rslt"}, conv_rslt, 0);
    chk({tag, "_col"}, rslt_col, 0);
    chk({tag, "_data_addr"}, data_rd_addr, 0);
    chk({tag, "_row_cnt"}, row_cnt, 0);
    chk({tag, "_param_addr"}, param_rd_addr, 0);
    chk({tag, "_conv_cnt"}, conv_cnt, 0);
  endtask

  task automatic start_run();
    push_expected();
    ptrace.delete();
    addr_cyc = -1;
    lat_done = 1'b0;
    cal_start = 1'b1;
    @(negedge sclk);
    cal_start = 1'b0;
  endtask

  task automatic run(input bit repulse);
    int d0, r0;
    bit got;
    d0 = done_cnt;
    r0 = res_cnt;
    start_run();
    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      cal_start = repulse && (i == 40);
      @(negedge sclk);
      got = (done_cnt != d0);
    end
    cal_start = 1'b0;
    chk("done_seen", got, 1);
    repeat (5) @(negedge sclk);
    chk("done_pulses", done_cnt - d0, 1);
    chk("result_count", res_cnt - r0, N_RES);
    chk("queue_left", q.size(), 0);
    chk("busy_after_done", busy, 0);
    q.delete();
  endtask

  // Monitor: scoreboard pops, done counting, kernel-1 address trace, first-result latency.
  always @(negedge sclk) begin
    if (done) done_cnt++;
    if (busy && int'(conv_cnt) == 1 && (ptrace.size() == 0 || ptrace[$] != int'(param_rd_addr)))
      ptrace.push_back(int'(param_rd_addr));
    if (busy && addr_cyc < 0 && int'(data_rd_addr) == K - 1) addr_cyc = cyc;
    if (conv_rslt_vld) begin
      res_cnt++;
      if (!lat_done) begin
        lat_done = 1'b1;
        chk("first_latency", cyc - addr_cyc, 4);
      end
      chk("rslt_expected", q.size() > 0, 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rslt", longint'(conv_rslt), e.val);
        chk("rslt_col", rslt_col, e.col);
      end
    end
  end

  initial begin
    int d0;
    repeat (3) @(negedge sclk);
    check_idle_zero("reset");
    s_rst_n = 1'b1;
    repeat (2) @(negedge sclk);

    set_uniform(1, 1, 0);
    run(1'b0);
    chk("k1_trace_len", ptrace.size(), K);
    for (int i = 0; i < K; i++) chk("k1_param_addr", (ptrace.size() > i) ? ptrace[i] : -1, K + i);

    set_uniform(0, 0, -3);
    img[4][4] = 1;
    for (int k = 0; k < N_KER; k++)
      for (int r = 0; r < K; r++) for (int c = 0; c < K; c++) wt[k][r][c] = r * 5 + c;
    run(1'b0);

    set_uniform(255, 127, 127);
    run(1'b0);
    set_uniform(255, -128, 127);
    run(1'b0);

    set_uniform(1, -1, 0);
    run(1'b1);

    rand_fill(15, -8, 7);
    run(1'b0);
    rand_fill(255, -128, 127);
    run(1'b0);

    rand_fill(15, -8, 7);
    d0 = done_cnt;
    start_run();
    repeat (25) @(negedge sclk);
    s_rst_n = 1'b0;
    #1;
    check_idle_zero("midrst");
    q.delete();
    repeat (2) @(negedge sclk);
    s_rst_n = 1'b1;
    repeat (30) @(negedge sclk);
    chk("no_done_after_reset", done_cnt - d0, 0);
    chk("idle_after_reset", busy, 0);

    rand_fill(31, -16, 15);
    run(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
